sa_out: RTL

- Output-side switch allocator for one router output port; the reading end of the per-input route-computed FIFOs.
- Each cycle it examines the five input FIFO heads (N, E, W, S, L), each tagged with a computed direction.
- It picks, by round robin, one head whose direction matches this port and pops it (rinc).
- It forwards the flit through a one-deep output register with valid/ready handshake. Wormhole lock holds the port from head flit to tail flit.
- One instance per output direction in the router top.

---
 rtl/sa_out_pkg.sv | 35 +++
 rtl/sa_out_if.sv | 29 ++
 rtl/sa_out_rr_arb5.sv | 30 +++
 rtl/sa_out.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sa_out_pkg.sv
// Shared NoC definitions for the output-side switch allocator: flit type codes
// and field position, direction codes, port count and arbiter helpers.
package sa_out_pkg;

  localparam int NUM_PORTS = 5;
  localparam int DIR_W     = 4;
  localparam int PTR_W     = 3;

  // Flit type lives in the two most significant bits of each flit.
  localparam int TYPE_W = 2;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  localparam logic [DIR_W-1:0] DIR_N = 4'd0;
  localparam logic [DIR_W-1:0] DIR_E = 4'd1;
  localparam logic [DIR_W-1:0] DIR_W_ = 4'd2;
  localparam logic [DIR_W-1:0] DIR_S = 4'd3;
  localparam logic [DIR_W-1:0] DIR_L = 4'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } sa_state_e;

  // Cyclic successor over input indices 0..4.
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    return (i >= 3'd4) ? 3'd0 : i + 3'd1;
  endfunction

endpackage

// File: rtl/sa_out_if.sv
// Bus bundle between the input FIFO heads, the allocator and the downstream hop.
// Handshake: a flit transfers downstream on a clock edge where valid_out and
// ready_in are both 1; valid_out never depends combinationally on ready_in,
// and data_out is held stable while valid_out=1 and ready_in=0. On the FIFO
// side, fifo_rinc[i] pops the head of input i on that same edge.
interface sa_out_if #(
  parameter int DATASIZE = 40
);
  logic [5*DATASIZE-1:0] fifo_rdata;
  logic [19:0]           fifo_dir;
  logic [4:0]            fifo_rempty;
  logic [4:0]            fifo_rinc;
  logic [DATASIZE-1:0]   data_out;
  logic                  valid_out;
  logic                  ready_in;
  logic                  err_seq;

  // Allocator side.
  modport master (
    input  fifo_rdata, fifo_dir, fifo_rempty, ready_in,
    output fifo_rinc, data_out, valid_out, err_seq
  );

  // FIFO/downstream environment side.
  modport slave (
    output fifo_rdata, fifo_dir, fifo_rempty, ready_in,
    input  fifo_rinc, data_out, valid_out, err_seq
  );
endinterface

// File: rtl/sa_out_rr_arb5.sv
// Five-way round-robin arbiter: first request at or after ptr, cyclic over 0..4.
module rr_arb5
  import sa_out_pkg::*;
(
  input  logic [4:0]       req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [4:0]       gnt_oh_o,
  output logic [PTR_W-1:0] gnt_idx_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan all five candidates starting at the pointer; first hit wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = (ptr_i > 3'd4) ? 3'd0 : ptr_i;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        gnt_oh_o[idx]  = 1'b1;
        gnt_idx_o      = idx;
      end
      idx = next_idx(idx);
    end
  end

endmodule

// File: rtl/sa_out.sv
// Output-port switch allocator: round-robin among matching FIFO heads, wormhole
// lock from HEAD to TAIL, one-deep registered output with valid/ready.
// Optional packet counter output pkt_cnt enabled by macro SA_PKT_CNT_EN.
module sa_out
  import sa_out_pkg::*;
#(
  parameter int               DATASIZE = 40,
  parameter logic [DIR_W-1:0] OUT_DIR  = 4'd0
) (
  input  logic             rc_clk,
  input  logic             rst_n,
  sa_out_if.master         bus,
  output sa_state_e        dbg_state,
  output logic [PTR_W-1:0] dbg_rr_ptr,
  output logic [PTR_W-1:0] dbg_owner
`ifdef SA_PKT_CNT_EN
  ,
  output logic [15:0]      pkt_cnt
`endif
);

  sa_state_e               state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [DATASIZE-1:0]     data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  flit_type_e              head_type [NUM_PORTS];
  logic [4:0]              req, elig, bad;
  logic [4:0]              gnt_oh;
  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W-1:0]        sel_idx;
  logic [DATASIZE-1:0]     sel_flit;
  flit_type_e              sel_type;
  logic                    ld, pop;
  logic [4:0]              rinc;

  // Decode each head: type, direction match, and whether it may open a packet.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      head_type[i] = flit_type_e'(bus.fifo_rdata[i*DATASIZE + DATASIZE - TYPE_W +: TYPE_W]);
      req[i]  = !bus.fifo_rempty[i] && (bus.fifo_dir[i*DIR_W +: DIR_W] == OUT_DIR);
      elig[i] = req[i] && (head_type[i] == FT_HEAD || head_type[i] == FT_SINGLE);
      bad[i]  = req[i] && (head_type[i] == FT_BODY || head_type[i] == FT_TAIL);
    end
  end

  rr_arb5 u_arb (
    .req_i     (elig),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  // Select the candidate input: arbiter winner when idle, the owner when locked.
  always_comb begin
    sel_idx  = (state_q == ST_IDLE) ? gnt_idx : owner_q;
    sel_flit = '0;
    sel_type = FT_BODY;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_idx == 3'(i)) begin
        sel_flit = bus.fifo_rdata[i*DATASIZE +: DATASIZE];
        sel_type = head_type[i];
      end
    end
  end

  // Next-state, pop strobe and output register update.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    valid_d  = valid_q;
    err_d    = err_q;
    pop      = 1'b0;
    rinc     = '0;
    ld       = !valid_q || bus.ready_in;

    // Downstream took the current flit; a pop below refills it.
    if (bus.ready_in) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bad) err_d = 1'b1;
        if (ld && |gnt_oh) begin
          pop = 1'b1;
          if (sel_type == FT_HEAD) begin
            state_d = ST_LOCKED;
            owner_d = gnt_idx;
          end else begin
            rr_ptr_d = next_idx(gnt_idx);
          end
        end
      end
      ST_LOCKED: begin
        if (ld && !bus.fifo_rempty[owner_q]) begin
          pop = 1'b1;
          if (sel_type == FT_TAIL) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_idx(owner_q);
          end else if (sel_type == FT_HEAD || sel_type == FT_SINGLE) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      rinc[sel_idx] = 1'b1;
      data_d        = sel_flit;
      valid_d       = 1'b1;
    end
  end

  // State, lock and output register.
  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

`ifdef SA_PKT_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Count completed packets: every popped TAIL or SINGLE, wrapping at 16 bits.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pop && (sel_type == FT_TAIL || sel_type == FT_SINGLE))
      pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  // Packet counter register.
  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

  assign bus.fifo_rinc = rinc;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.err_seq   = err_q;
  assign dbg_state     = state_q;
  assign dbg_rr_ptr    = rr_ptr_q;
  assign dbg_owner     = owner_q;

endmodule
